mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//   Iterative multiply/divide unit for MULT, MULTU, DIV, DIVU, MTHI, MTLO.
//   Consumes the two register-file read ports (readData1 -> srcA, readData2 -> srcB).
//   Holds the HI/LO architectural registers.
//   Control stalls on busy; MFHI/MFLO select hi/lo onto the register-file writeData path.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are each WIDTH bits
// PORTS
//   clk    in   1      rising-edge clock, sole clock domain
//   rst    in   1      reset, asynchronous assert, active-low (0 = reset)
//   start  in   1      launch op; accepted only when busy=0
//   op     in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   srcA   in   WIDTH  multiplicand / dividend (rs)
//   srcB   in   WIDTH  multiplier / divisor (rt)
//   mthi   in   1      write srcA into HI (idle only)
//   mtlo   in   1      write srcA into LO (idle only)
//   busy   out  1      operation in flight; HI/LO stale
//   done   out  1      one-cycle pulse: HI/LO updated this cycle
//   hi     out  WIDTH  HI register (registered)
//   lo     out  WIDTH  LO register (registered)
// BEHAVIOUR
//   Reset (rst=0, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0.
//     Takes effect immediately, including mid-operation; the in-flight op is discarded.
//   States and transitions:
//     IDLE  -> RUN when start accepted.
//     RUN   -> FIX after WIDTH iterations (one bit per cycle).
//     FIX   -> IDLE, asserting done.
//   Timing:
//     start sampled at edge E0 -> busy=1 from E0 through E0+WIDTH.
//     At edge E0+WIDTH+1: hi/lo written, done=1 for that one cycle, busy=0.
//     Total latency WIDTH+1 cycles (33 at default).
//   Signed ops (MULT, DIV):
//     Latch |srcA| and |srcB| as WIDTH-bit unsigned (|0x80000000| = 0x80000000).
//     Run the unsigned algorithm; apply sign correction in FIX.
//     Product sign = a^b; quotient sign = a^b; remainder sign = sign of dividend.
//   Multiply: shift-add, 2*WIDTH-bit product; hi = product[2W-1:W], lo = product[W-1:0].
//   Divide: restoring, one quotient bit per cycle; lo = quotient, hi = remainder.
//   Divide by zero (srcB==0 at start): skip RUN and go directly to FIX.
//     busy=1 for exactly one cycle, then lo = all ones, hi = srcA as latched.
//     No sign correction applied.
//   Overflow: DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; no trap.
//   start while busy=1: ignored, no side effect; control must hold start until busy=0.
//   mthi/mtlo while busy=1: ignored.
//   mthi/mtlo while idle: hi or lo <= srcA at next edge; both may be written in one cycle.
//   start together with mthi/mtlo while idle: start wins; mthi/mtlo dropped.
//   Operands and op are latched at start; later srcA/srcB/op changes have no effect.
//   Iteration counter: clog2(WIDTH)+1 bits; no wrap within an op.
// STRUCTURE
//   Package mdu_pkg:
//     op encodings MDU_MULT/MULTU/DIV/DIVU.
//     State enum {IDLE, RUN, FIX}.
//   Sub-module mdu_step (combinational): one shift-add or restore-subtract iteration
//     on {acc, operand}.
//   Top level holds FSM, counter, sign flags, HI/LO registers and mthi/mtlo muxing.
// TESTING
//   MULTU 0xFFFFFFFF*0xFFFFFFFF
//     -> busy 33 cycles, then done pulse; hi=0xFFFFFFFE, lo=0x00000001.
//   MULT -3*7
//     -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
//   DIV -7/2
//     -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   DIVU 7/2
//     -> lo=3, hi=1.
//   DIV 0x80000000/0xFFFFFFFF
//     -> lo=0x80000000, hi=0.
//   DIVU 5/0
//     -> busy for 1 cycle; lo=0xFFFFFFFF, hi=5.
//   Illegal-while-busy and reset:
//     start and mthi pulsed at cycle 5 of a MULT -> result unchanged, hi not overwritten.
//     rst=0 at cycle 10 -> hi=lo=0 and busy=0 without waiting for a clock edge.
//   Idle writes and priority:
//     mthi then mtlo idle with srcA=0x1234 -> hi=lo=0x1234.
//     start+mtlo in the same cycle -> op runs, lo holds the op result only.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: default width,
// operation encodings and controller states.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration on {acc, oper}: a shift-add multiply step or a
// restoring-divide step, selected by i_is_div.
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_oper,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_oper
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    // Multiply: add the multiplicand when the multiplier LSB is set, then shift
    // the {carry, acc, oper} pair right so the product fills {acc, oper}.
    assign w_sum = {1'b0, i_acc} + (i_oper[0] ? {1'b0, i_m} : '0);

    // Divide: partial remainder stays below the divisor, so the difference
    // always fits in WIDTH bits when the trial subtraction succeeds.
    assign w_shift = {i_acc, i_oper[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_m});
    assign w_diff  = w_shift[WIDTH-1:0] - i_m;

    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        o_acc  = w_sum[WIDTH:1];
        o_oper = {w_sum[0], i_oper[WIDTH-1:1]};
        if (i_is_div) begin
            o_acc  = w_ge ? w_diff : w_shift[WIDTH-1:0];
            o_oper = {i_oper[WIDTH-2:0], w_ge};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers; one bit per
// cycle on magnitudes, with sign correction in a final FIX cycle.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mdu_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_oper;
    logic [WIDTH-1:0]   r_m;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_signed;
    logic               w_is_div;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_div_zero;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]   w_oper_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_signed   = (op == MDU_MULT) || (op == MDU_DIV);
    assign w_is_div   = (op == MDU_DIV) || (op == MDU_DIVU);
    assign w_a_neg    = w_signed & srcA[WIDTH-1];
    assign w_b_neg    = w_signed & srcB[WIDTH-1];
    assign w_div_zero = w_is_div && (srcB == '0);
    assign w_abs_a    = w_a_neg ? -srcA : srcA;
    assign w_abs_b    = w_b_neg ? -srcB : srcB;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_is_div),
        .i_acc    (r_acc),
        .i_oper   (r_oper),
        .i_m      (r_m),
        .o_acc    (w_acc_next),
        .o_oper   (w_oper_next)
    );

    // Remainder takes the dividend's sign; product and quotient take a^b.
    assign w_prod     = {r_acc, r_oper};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
    assign w_quot_fix = r_neg_q ? -r_oper : r_oper;
    assign w_rem_fix  = r_neg_r ? -r_acc : r_acc;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dbz    <= 1'b0;
            r_acc    <= '0;
            r_oper   <= '0;
            r_m      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_acc    <= '0;
                        r_m      <= w_abs_b;
                        if (w_div_zero) begin
                            r_dbz   <= 1'b1;
                            r_oper  <= srcA;
                            r_state <= FIX;
                        end else begin
                            r_dbz   <= 1'b0;
                            r_oper  <= w_abs_a;
                            r_state <= RUN;
                        end
                    end else begin
                        if (mthi) r_hi <= srcA;
                        if (mtlo) r_lo <= srcA;
                    end
                end
                RUN: begin
                    r_acc  <= w_acc_next;
                    r_oper <= w_oper_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
                end
                FIX: begin
                    if (r_dbz) begin
                        r_lo <= '1;
                        r_hi <= r_oper;
                    end else if (r_is_div) begin
                        r_lo <= w_quot_fix;
                        r_hi <= w_rem_fix;
                    end else begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with per-cycle compare,
// directed literal cases and randomized traffic.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op    = 2'b00;
    logic [W-1:0] srcA  = '0;
    logic [W-1:0] srcB  = '0;
    logic         mthi  = 1'b0;
    logic         mtlo  = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_hi   = '0;
    logic [W-1:0] exp_lo   = '0;
    logic         exp_busy = 1'b0;
    logic         exp_done = 1'b0;
    int           remaining = 0;
    logic [63:0]  pend = '0;
    logic         check_en = 1'b0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .srcA  (srcA),
        .srcB  (srcB),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} of one operation, from plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // Cycle-level expectation: an accepted op keeps busy for WIDTH+1 cycles
    // (1 on divide-by-zero), then publishes its result with a done pulse.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_hi    = '0;
            exp_lo    = '0;
            exp_busy  = 1'b0;
            exp_done  = 1'b0;
            remaining = 0;
        end else begin
            exp_done = 1'b0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    {exp_hi, exp_lo} = pend;
                    exp_done = 1'b1;
                    exp_busy = 1'b0;
                end
            end else if (start) begin
                pend      = model(op, srcA, srcB);
                remaining = (op[1] && srcB == 0) ? 1 : W + 1;
                exp_busy  = 1'b1;
            end else begin
                if (mthi) exp_hi = srcA;
                if (mtlo) exp_lo = srcA;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && check_en) begin
            check("busy", 64'(busy), 64'(exp_busy));
            check("done", 64'(done), 64'(exp_done));
            check("hi",   64'(hi),   64'(exp_hi));
            check("lo",   64'(lo),   64'(exp_lo));
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic with_mthi, input logic with_mtlo);
        @(posedge clk); #1;
        start = 1'b1; op = o; srcA = a; srcB = b; mthi = with_mthi; mtlo = with_mtlo;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'($urandom); srcA = $urandom; srcB = $urandom;
    endtask

    task automatic wait_done(output int n_busy, output bit seen);
        n_busy = 0;
        seen   = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) n_busy++;
        end
        check("done_seen", 64'(seen), 64'd1);
    endtask

    task automatic do_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] want_hi,
                         input logic [W-1:0] want_lo, input int want_busy);
        int  nb;
        bit  seen;
        start_op(o, a, b, 1'b0, 1'b0);
        wait_done(nb, seen);
        check({name, "_hi"}, 64'(hi), 64'(want_hi));
        check({name, "_lo"}, 64'(lo), 64'(want_lo));
        if (want_busy > 0) check({name, "_busy_cycles"}, 64'(nb), 64'(want_busy));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h0;
            3: return 32'($urandom % 16);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int  nb;
        bit  seen;

        #3;
        check("rst_hi",   64'(hi),   64'd0);
        check("rst_lo",   64'(lo),   64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        check_en = 1'b1;

        do_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33);
        do_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        do_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        do_op("divu",      2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 0);
        do_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 0);
        do_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);

        // start and mthi pulsed while a MULT is in flight must be ignored.
        start_op(2'b00, 32'd6, 32'd7, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1; start = 1'b1; op = 2'b11; srcA = 32'hDEAD; srcB = 32'd3; mthi = 1'b1;
        @(posedge clk); #1; start = 1'b0; mthi = 1'b0;
        wait_done(nb, seen);
        check("busy_ign_hi", 64'(hi), 64'd0);
        check("busy_ign_lo", 64'(lo), 64'd42);
        @(negedge clk);
        check("busy_ign_idle", 64'(busy), 64'd0);

        @(posedge clk); #1; srcA = 32'h1234; mthi = 1'b1;
        @(posedge clk); #1; mthi = 1'b0; mtlo = 1'b1;
        @(posedge clk); #1; mtlo = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        check("mtlo_lo", 64'(lo), 64'h1234);

        // start wins over a simultaneous mtlo.
        @(posedge clk); #1; srcA = 32'h5555; mtlo = 1'b1;
        @(posedge clk); #1; mtlo = 1'b0;
        start_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b1);
        check("prio_lo_hold", 64'(lo), 64'h5555);
        wait_done(nb, seen);
        check("prio_hi", 64'(hi), 64'd0);
        check("prio_lo", 64'(lo), 64'd12);

        // Asynchronous reset in the middle of an operation.
        @(posedge clk); #1; srcA = 32'hABCD; mthi = 1'b1;
        @(posedge clk); #1; mthi = 1'b0;
        start_op(2'b00, 32'd1000, 32'd77, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #2; rst = 1'b0;
        #1;
        check("arst_hi",   64'(hi),   64'd0);
        check("arst_lo",   64'(lo),   64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk); #1; rst = 1'b1;
        repeat (3) @(posedge clk);

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            start = ($urandom % 8 == 0);
            op    = 2'($urandom);
            srcA  = pick();
            srcB  = ($urandom % 8 == 0) ? 32'h0 : pick();
            mthi  = ($urandom % 6 == 0);
            mtlo  = ($urandom % 6 == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2 * W) @(posedge clk);
        @(negedge clk);
        check("drain_idle", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
